input_logic: RTL and testbench

- User-input front end of the 10-bit processor; the counterpart of the output/visualisation logic.
- Synchronises the raw slide switches and debounces the two push-buttons (Execute, Peek).
- Produces a one-cycle EXEC start pulse, a clean PEEKb level, and a DATA word for the Din/RDA1 path.
- EXEC is gated by an instruction-busy handshake with the controller's DONE (Clr) signal.

---
 rtl/input_logic_pkg.sv | 21 ++
 rtl/input_logic_if.sv | 37 +++
 rtl/input_logic_key_debouncer.sv | 93 +++++++++
 rtl/input_logic.sv | 91 +++++++++
 tb/tb_input_logic.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/input_logic_pkg.sv
// -----------------------------------------------------------------------------
// input_logic_pkg
// Shared types and defaults for the user-input front end of the 10-bit
// processor.
//   deb_state_t             : key debouncer state encoding
//   DATA_W                  : default switch bank / DATA width
//   DEBOUNCE_CYCLES_DEFAULT : default stable-cycle count (10 ms at 50 MHz)
// -----------------------------------------------------------------------------
package input_logic_pkg;

  localparam int DATA_W                  = 10;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

endpackage : input_logic_pkg

// File: rtl/input_logic_if.sv
// -----------------------------------------------------------------------------
// input_logic_if
// Bundles the front-end signals between the board/controller side (master)
// and the input logic block (slave).
//   SW_RAW    : raw slide switches (asynchronous)
//   EXECb_RAW : raw Execute key, active-low, bouncy
//   PEEKb_RAW : raw Peek key, active-low, bouncy
//   DONE      : controller Clr, 1 = instruction complete
//   DATA      : registered switch word to the processor
//   EXEC      : single-cycle start pulse
//   PEEKb     : debounced Peek level, 1 = released
//   BUSY      : instruction in flight
// -----------------------------------------------------------------------------
interface input_logic_if #(
  parameter int DATA_W = input_logic_pkg::DATA_W
);

  logic [DATA_W-1:0] SW_RAW;
  logic              EXECb_RAW;
  logic              PEEKb_RAW;
  logic              DONE;
  logic [DATA_W-1:0] DATA;
  logic              EXEC;
  logic              PEEKb;
  logic              BUSY;

  modport master (
    output SW_RAW, EXECb_RAW, PEEKb_RAW, DONE,
    input  DATA, EXEC, PEEKb, BUSY
  );

  modport slave (
    input  SW_RAW, EXECb_RAW, PEEKb_RAW, DONE,
    output DATA, EXEC, PEEKb, BUSY
  );

endinterface : input_logic_if

// File: rtl/input_logic_key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
// Synchronises one active-low push-button and accepts a level change only
// after DEBOUNCE_CYCLES consecutive stable samples.
//   CLK       : system clock
//   RSTb      : asynchronous active-low reset
//   raw_b     : raw key, active-low, asynchronous
//   level_b   : debounced level, 0 = pressed
//   press_evt : one-cycle pulse in the cycle the press is accepted
// -----------------------------------------------------------------------------
module key_debouncer
  import input_logic_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic CLK,
  input  logic RSTb,
  input  logic raw_b,
  output logic level_b,
  output logic press_evt
);

  // A single-cycle debounce still needs a 1-bit counter to exist.
  localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced_b;
  deb_state_t             state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // Synchroniser: idle level of the key is 1 (released).
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) sync_q <= '1;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw_b};
  end

  assign synced_b = sync_q[SYNC_STAGES-1];

  // State register
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state_q <= RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter saturates at CNT_MAX by leaving the wait state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RELEASED: begin
        if (!synced_b) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (synced_b)              state_d = RELEASED;
        else if (cnt_q == CNT_MAX) state_d = PRESSED;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      PRESSED: begin
        if (synced_b) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!synced_b)             state_d = PRESSED;
        else if (cnt_q == CNT_MAX) state_d = RELEASED;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: level comes straight from the state register; press_evt marks
  // the PRESS_WAIT -> PRESSED transition so downstream can register it.
  always_comb begin
    level_b   = !((state_q == PRESSED) || (state_q == RELEASE_WAIT));
    press_evt = (state_q == PRESS_WAIT) && !synced_b && (cnt_q == CNT_MAX);
  end

endmodule : key_debouncer

// File: rtl/input_logic.sv
// -----------------------------------------------------------------------------
// input_logic
// User-input front end of the 10-bit processor: synchronises the slide
// switches, debounces Execute and Peek, and runs the EXEC/BUSY handshake
// with the controller's DONE.
//   CLK  : system clock
//   RSTb : asynchronous active-low reset
//   bus  : input_logic_if.slave (SW_RAW, EXECb_RAW, PEEKb_RAW, DONE in;
//          DATA, EXEC, PEEKb, BUSY out)
// -----------------------------------------------------------------------------
module input_logic #(
  parameter int DATA_W          = input_logic_pkg::DATA_W,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = input_logic_pkg::DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic          CLK,
  input  logic          RSTb,
  input_logic_if.slave  bus
);

  import input_logic_pkg::*;

  logic [DATA_W-1:0] sw_sync_q [SYNC_STAGES];
  logic              exec_press;
  logic              exec_level_unused;
  logic              peek_level_b;
  logic              exec_d, exec_q;
  logic              busy_d, busy_q;
  logic [DATA_W-1:0] data_d, data_q;

  // Switch synchroniser: not debounced, slide switches do not bounce harmfully.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      for (int i = 0; i < SYNC_STAGES; i++) sw_sync_q[i] <= '0;
    end else begin
      sw_sync_q[0] <= bus.SW_RAW;
      for (int i = 1; i < SYNC_STAGES; i++) sw_sync_q[i] <= sw_sync_q[i-1];
    end
  end

  key_debouncer #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_exec_deb (
    .CLK       (CLK),
    .RSTb      (RSTb),
    .raw_b     (bus.EXECb_RAW),
    .level_b   (exec_level_unused),
    .press_evt (exec_press)
  );

  key_debouncer #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_peek_deb (
    .CLK       (CLK),
    .RSTb      (RSTb),
    .raw_b     (bus.PEEKb_RAW),
    .level_b   (peek_level_b),
    .press_evt ()
  );

  // Handshake: a press during BUSY (including the DONE cycle) is dropped.
  // DATA is captured in the EXEC cycle because busy_q is still 0 there.
  always_comb begin
    exec_d = exec_press && !busy_q;
    busy_d = busy_q;
    if (exec_d)                busy_d = 1'b1;
    else if (busy_q && bus.DONE) busy_d = 1'b0;
    data_d = busy_q ? data_q : sw_sync_q[SYNC_STAGES-1];
  end

  // Output register stage
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      exec_q <= 1'b0;
      busy_q <= 1'b0;
      data_q <= '0;
    end else begin
      exec_q <= exec_d;
      busy_q <= busy_d;
      data_q <= data_d;
    end
  end

  assign bus.DATA  = data_q;
  assign bus.EXEC  = exec_q;
  assign bus.BUSY  = busy_q;
  assign bus.PEEKb = peek_level_b;

endmodule : input_logic

// File: tb/tb_input_logic.sv
// -----------------------------------------------------------------------------
// tb_input_logic
// Self-checking bench for input_logic with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Each qualifying Execute press pushes the expected EXEC cycle and DATA word
// into a queue; a negedge monitor pops and compares whenever EXEC is seen.
// -----------------------------------------------------------------------------
module tb_input_logic;

  localparam int DW  = 10;
  localparam int LAT = 7;   // SYNC_STAGES + DEBOUNCE_CYCLES + 1

  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } exp_t;

  logic CLK;
  logic RSTb;
  int   cyc;
  int   n_tests;
  int   n_fail;
  exp_t sb_q[$];

  input_logic_if #(.DATA_W(DW)) bus ();

  input_logic #(
    .DATA_W          (DW),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .CLK  (CLK),
    .RSTb (RSTb),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push_exec(input logic [DW-1:0] d);
    exp_t e;
    e.cyc  = cyc + LAT;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Scoreboard monitor
  always @(negedge CLK) begin
    if (bus.EXEC === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("exec_spurious", 32'(bus.EXEC), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("exec_cycle", 32'(cyc), 32'(e.cyc));
        chk("exec_data", 32'(bus.DATA), 32'(e.data));
        chk("exec_busy", 32'(bus.BUSY), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    RSTb          = 1'b0;
    bus.SW_RAW    = '0;
    bus.EXECb_RAW = 1'b1;
    bus.PEEKb_RAW = 1'b1;
    bus.DONE      = 1'b0;
    tick(3);
    chk("rst_data",  32'(bus.DATA),  32'd0);
    chk("rst_exec",  32'(bus.EXEC),  32'd0);
    chk("rst_peekb", 32'(bus.PEEKb), 32'd1);
    chk("rst_busy",  32'(bus.BUSY),  32'd0);
    RSTb = 1'b1;
    tick(2);

    // 1: idle switch tracking, then asynchronous reset mid-count
    bus.SW_RAW = 10'h2A5;
    tick(2);
    chk("t1_data_early", 32'(bus.DATA), 32'd0);
    tick(1);
    chk("t1_data", 32'(bus.DATA), 32'h2A5);
    chk("t1_exec", 32'(bus.EXEC), 32'd0);
    chk("t1_peekb", 32'(bus.PEEKb), 32'd1);
    chk("t1_busy", 32'(bus.BUSY), 32'd0);
    bus.EXECb_RAW = 1'b0;
    bus.PEEKb_RAW = 1'b0;
    tick(4);
    RSTb = 1'b0;
    #1;
    chk("t1_rst_data",  32'(bus.DATA),  32'd0);
    chk("t1_rst_exec",  32'(bus.EXEC),  32'd0);
    chk("t1_rst_peekb", 32'(bus.PEEKb), 32'd1);
    chk("t1_rst_busy",  32'(bus.BUSY),  32'd0);
    bus.EXECb_RAW = 1'b1;
    bus.PEEKb_RAW = 1'b1;
    tick(2);
    RSTb = 1'b1;
    tick(12);
    chk("t1_post_rst_peekb", 32'(bus.PEEKb), 32'd1);
    chk("t1_post_rst_busy", 32'(bus.BUSY), 32'd0);

    // 2: clean press, DATA frozen while busy
    bus.SW_RAW = 10'h155;
    tick(4);
    bus.EXECb_RAW = 1'b0;
    push_exec(10'h155);
    tick(LAT + 1);
    chk("t2_busy", 32'(bus.BUSY), 32'd1);
    chk("t2_data", 32'(bus.DATA), 32'h155);
    bus.SW_RAW = 10'h3FF;
    tick(5);
    chk("t2_data_frozen", 32'(bus.DATA), 32'h155);
    bus.EXECb_RAW = 1'b1;
    tick(10);

    // 4a: press while busy is discarded, DONE releases BUSY
    bus.EXECb_RAW = 1'b0;
    tick(12);
    bus.EXECb_RAW = 1'b1;
    tick(10);
    chk("t4_still_busy", 32'(bus.BUSY), 32'd1);
    chk("t4_data_frozen", 32'(bus.DATA), 32'h155);
    bus.DONE = 1'b1;
    tick(1);
    bus.DONE = 1'b0;
    chk("t4_busy_clr", 32'(bus.BUSY), 32'd0);
    tick(1);
    chk("t4_data_track", 32'(bus.DATA), 32'h3FF);
    bus.SW_RAW = 10'h0AA;
    tick(3);
    chk("t4_data_track2", 32'(bus.DATA), 32'h0AA);
    bus.DONE = 1'b1;
    tick(1);
    bus.DONE = 1'b0;
    chk("t4_done_idle", 32'(bus.BUSY), 32'd0);

    // 3: bouncy press, then long hold
    bus.EXECb_RAW = 1'b0; tick(2);
    bus.EXECb_RAW = 1'b1; tick(1);
    bus.EXECb_RAW = 1'b0; tick(2);
    bus.EXECb_RAW = 1'b1; tick(1);
    bus.EXECb_RAW = 1'b0;
    push_exec(10'h0AA);
    tick(100);
    bus.EXECb_RAW = 1'b1;
    tick(10);
    chk("t3_busy", 32'(bus.BUSY), 32'd1);
    bus.DONE = 1'b1;
    tick(1);
    bus.DONE = 1'b0;
    chk("t3_busy_clr", 32'(bus.BUSY), 32'd0);

    // 4b: a fresh press after DONE is accepted
    bus.SW_RAW = 10'h1C3;
    tick(3);
    bus.EXECb_RAW = 1'b0;
    push_exec(10'h1C3);
    tick(LAT + 2);
    bus.EXECb_RAW = 1'b1;
    tick(10);
    chk("t4_new_busy", 32'(bus.BUSY), 32'd1);

    // 5: DONE coincides with press_evt -> press dropped
    bus.EXECb_RAW = 1'b0;
    tick(LAT - 1);
    bus.DONE = 1'b1;
    tick(1);
    bus.DONE = 1'b0;
    chk("t5_busy_clr", 32'(bus.BUSY), 32'd0);
    chk("t5_no_exec", 32'(bus.EXEC), 32'd0);
    tick(3);
    bus.EXECb_RAW = 1'b1;
    tick(10);
    chk("t5_busy_stays", 32'(bus.BUSY), 32'd0);

    // 6: Peek level in both directions, then a short glitch
    bus.PEEKb_RAW = 1'b0;
    tick(LAT - 1);
    chk("t6_peek_early", 32'(bus.PEEKb), 32'd1);
    tick(1);
    chk("t6_peek_low", 32'(bus.PEEKb), 32'd0);
    tick(3);
    bus.PEEKb_RAW = 1'b1;
    tick(LAT - 1);
    chk("t6_rel_early", 32'(bus.PEEKb), 32'd0);
    tick(1);
    chk("t6_peek_high", 32'(bus.PEEKb), 32'd1);
    tick(2);
    bus.PEEKb_RAW = 1'b0;
    tick(3);
    bus.PEEKb_RAW = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("t6_glitch", 32'(bus.PEEKb), 32'd1);
    end

    tick(5);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_input_logic
